// File: rtl/ifu_line_responder.sv
// rtl/ifu_line_responder.sv - fixed-latency 512b line responder for the IFU line-fetch port
// Optional IFU_RESP_JITTER_EN adds 0..7 LFSR-chosen wait cycles per request.
module ifu_line_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_index_valid,
  input  logic [18:0]       pc_index,
  input  logic              req_flush,
  output logic              pc_index_accept,
  output logic              busy,
  output logic              pc_index_ready,
  output logic [511:0]      pc_read_inst,
  output logic              pc_operation_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [511:0]      wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  state_t            state, state_next;
  logic [4:0]        cnt, cnt_next;
  logic [4:0]        cnt_init;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] read_idx;
  logic              load_line;
  logic [511:0]      mem [0:(1<<ADDR_W)-1];
  logic              unused_pc_bits;

  assign req_idx        = pc_index[ADDR_W+2:3];
  assign unused_pc_bits = ^pc_index;

`ifdef IFU_RESP_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cnt_init = LAT_M1 + {2'b00, lfsr[2:0]};
`else
  assign cnt_init = LAT_M1;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    idx_next          = idx;
    read_idx          = idx;
    load_line         = 1'b0;
    pc_index_accept   = 1'b0;
    pc_index_ready    = 1'b0;
    pc_operation_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (pc_index_valid && !req_flush && !rst) begin
          pc_index_accept = 1'b1;
          idx_next        = req_idx;
          cnt_next        = cnt_init;
          if (cnt_init == 5'd0) begin
            load_line  = 1'b1;
            read_idx   = req_idx;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A flush on the final wait cycle also skips the line load.
        if (req_flush) begin
          cnt_next   = 5'd0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 5'd1;
          if (cnt == 5'd1) begin
            load_line  = 1'b1;
            state_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (req_flush) begin
          state_next = S_IDLE;
        end else begin
          pc_index_ready = 1'b1;
          state_next     = S_DONE;
        end
      end
      S_DONE: begin
        pc_operation_done = 1'b1;
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 5'd0;
      idx          <= '0;
      pc_read_inst <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      if (load_line) pc_read_inst <= mem[read_idx];
    end
  end

  // Reads above see the pre-edge contents, so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule
